// File: rtl/pc_pkg.sv
// Shared definitions for the fetch-stage program counter: op encoding and default widths.
// Decode/control imports this too so both sides agree on the op values.
package pc_pkg;

   localparam int PC_ADDR_WIDTH   = 16;
   localparam int PC_INC_STEP     = 2;
   localparam int PC_OFFSET_WIDTH = 12;
   localparam int PC_RAS_DEPTH    = 4;
   localparam int PC_OP_WIDTH     = 3;

   // Encodings 6 and 7 are reserved and behave as HOLD.
   typedef enum logic [PC_OP_WIDTH-1:0] {
      PC_NEXT   = 3'd0,
      PC_HOLD   = 3'd1,
      PC_BRANCH = 3'd2,
      PC_JUMP   = 3'd3,
      PC_CALL   = 3'd4,
      PC_RET    = 3'd5
   } pc_op_e;

endpackage

// File: rtl/return_address_stack.sv
// Circular return-address stack: top pointer plus occupancy count.
// A push while full overwrites the oldest entry; a pop while empty is ignored.
module return_address_stack #(
   parameter int ADDR_WIDTH = 16,
   parameter int RAS_DEPTH  = 4
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  push_i,
   input  logic                  pop_i,
   input  logic [ADDR_WIDTH-1:0] data_i,
   output logic [ADDR_WIDTH-1:0] top_o,
   output logic                  full_o,
   output logic                  empty_o
);

   localparam int PW = $clog2(RAS_DEPTH);
   localparam int CW = PW + 1;

   logic [ADDR_WIDTH-1:0] mem_q [RAS_DEPTH];
   logic [PW-1:0]         top_q, top_d;
   logic [CW-1:0]         cnt_q, cnt_d;

   assign full_o  = (cnt_q == CW'(RAS_DEPTH));
   assign empty_o = (cnt_q == '0);
   assign top_o   = mem_q[top_q];

   // When full, top+1 wraps onto the oldest slot, so overwrite falls out naturally.
   always_comb begin
      top_d = top_q;
      cnt_d = cnt_q;
      if (push_i) begin
         top_d = top_q + 1'b1;
         cnt_d = full_o ? cnt_q : cnt_q + 1'b1;
      end else if (pop_i && !empty_o) begin
         top_d = top_q - 1'b1;
         cnt_d = cnt_q - 1'b1;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         top_q <= '1;
         cnt_q <= '0;
      end else begin
         top_q <= top_d;
         cnt_q <= cnt_d;
      end
   end

   // Entry contents need no reset; only the count decides validity.
   always_ff @(posedge clock) begin
      if (push_i && !reset)
         mem_q[top_d] <= data_i;
   end

endmodule

// File: rtl/pc_sequencer.sv
// Fetch-stage program counter: increment, branch, jump, call/return via RAS, stall,
// and sticky stack error flags.
module pc_sequencer
   import pc_pkg::*;
#(
   parameter int                    ADDR_WIDTH   = PC_ADDR_WIDTH,
   parameter int                    INC_STEP     = PC_INC_STEP,
   parameter logic [ADDR_WIDTH-1:0] RESET_ADDR   = '0,
   parameter int                    OFFSET_WIDTH = PC_OFFSET_WIDTH,
   parameter int                    RAS_DEPTH    = PC_RAS_DEPTH
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic                    stall,
   input  logic [PC_OP_WIDTH-1:0]  op,
   input  logic [ADDR_WIDTH-1:0]   inputAddress,
   input  logic [OFFSET_WIDTH-1:0] branchOffset,
   input  logic                    clearErr,
   output logic [ADDR_WIDTH-1:0]   outputAddress,
   output logic                    rasFull,
   output logic                    rasEmpty,
   output logic                    rasOverflow,
   output logic                    rasUnderflow
);

   logic [ADDR_WIDTH-1:0] pc_q, pc_d;
   logic [ADDR_WIDTH-1:0] pc_inc, pc_br, ras_top;
   logic                  ovf_q, ovf_d, unf_q, unf_d;
   logic                  push, pop;

   assign pc_inc = pc_q + ADDR_WIDTH'(INC_STEP);
   assign pc_br  = pc_q + ADDR_WIDTH'($signed(branchOffset));

   always_comb begin
      pc_d  = pc_q;
      ovf_d = ovf_q;
      unf_d = unf_q;
      push  = 1'b0;
      pop   = 1'b0;
      if (!stall) begin
         // Clear first so a same-cycle error set takes precedence.
         if (clearErr) begin
            ovf_d = 1'b0;
            unf_d = 1'b0;
         end
         case (pc_op_e'(op))
            PC_NEXT:   pc_d = pc_inc;
            PC_BRANCH: pc_d = pc_br;
            PC_JUMP:   pc_d = inputAddress;
            PC_CALL: begin
               push = 1'b1;
               pc_d = inputAddress;
               if (rasFull) ovf_d = 1'b1;
            end
            PC_RET: begin
               if (rasEmpty) begin
                  pc_d  = pc_inc;
                  unf_d = 1'b1;
               end else begin
                  pop  = 1'b1;
                  pc_d = ras_top;
               end
            end
            default:   pc_d = pc_q;
         endcase
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         pc_q  <= RESET_ADDR;
         ovf_q <= 1'b0;
         unf_q <= 1'b0;
      end else begin
         pc_q  <= pc_d;
         ovf_q <= ovf_d;
         unf_q <= unf_d;
      end
   end

   return_address_stack #(
      .ADDR_WIDTH (ADDR_WIDTH),
      .RAS_DEPTH  (RAS_DEPTH)
   ) u_ras (
      .clock   (clock),
      .reset   (reset),
      .push_i  (push),
      .pop_i   (pop),
      .data_i  (pc_inc),
      .top_o   (ras_top),
      .full_o  (rasFull),
      .empty_o (rasEmpty)
   );

   assign outputAddress = pc_q;
   assign rasOverflow   = ovf_q;
   assign rasUnderflow  = unf_q;

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
Parametrised next-generation program counter for the CPU fetch stage. Adds to the plain load/hold PC:
- auto-increment;
- PC-relative branch;
- absolute jump;
- call/return through an internal return-address stack (RAS);
- stall;
- sticky stack error flags.

It drives the instruction-memory address and takes its control from the decode/control unit.

Parameters:
ADDR_WIDTH, 16, PC and address width in bits.
INC_STEP, 2, byte increment applied on sequential fetch.
RESET_ADDR, 16'h0000, PC value loaded by reset.
OFFSET_WIDTH, 12, width of the signed branch offset.
RAS_DEPTH, 4, number of return-address entries (power of two, >=2).

Ports:
clock  in  1  system clock, all state updates on rising edge
reset  in  1  synchronous, active-high; reinitialises all state
stall  in  1  freeze: no state changes while high (reset still wins)
op  in  3  operation select (encoding below)
inputAddress  in  ADDR_WIDTH  absolute target for JUMP/CALL
branchOffset  in  OFFSET_WIDTH  signed byte offset for BRANCH
clearErr  in  1  clears sticky error flags
outputAddress  out  ADDR_WIDTH  current PC (registered)
rasFull  out  1  stack holds RAS_DEPTH entries
rasEmpty  out  1  stack holds 0 entries
rasOverflow  out  1  sticky: CALL issued while full
rasUnderflow  out  1  sticky: RET issued while empty

Behaviour:
- Interface: one clock (clock); reset is synchronous and active-high (reset).
- op encoding:
  - 0 NEXT
  - 1 HOLD
  - 2 BRANCH
  - 3 JUMP
  - 4 CALL
  - 5 RET
  - 6–7 reserved, behave as HOLD.
- Priority per edge: reset > stall > clearErr/op. clearErr and op act in the same cycle; if the same edge sets an error flag, the set wins.
- Reset values:
  - outputAddress = RESET_ADDR
  - stack count = 0, so rasEmpty = 1, rasFull = 0
  - rasOverflow = 0, rasUnderflow = 0
  - stack entry contents are don't-care.
- Latency: every op updates outputAddress on the next rising edge (1 cycle). Status flags are registered and change on that same edge.
- Let P = current outputAddress. All arithmetic is modulo 2^ADDR_WIDTH; wrap-around is silent.
  - NEXT: P <- P + INC_STEP.
  - HOLD: P unchanged.
  - BRANCH: P <- P + sign_extend(branchOffset). Offset is in bytes with no implicit shift; a negative offset moves backward.
  - JUMP: P <- inputAddress.
  - CALL: push P + INC_STEP, then P <- inputAddress.
  - RET: P <- popped entry.
- CALL when full:
  - stack is circular; the oldest entry is overwritten;
  - count stays RAS_DEPTH;
  - rasOverflow <- 1;
  - the jump still occurs.
- RET when empty:
  - P <- P + INC_STEP (fall through);
  - count stays 0;
  - rasUnderflow <- 1.
- rasFull = (count == RAS_DEPTH) and rasEmpty = (count == 0), both derived from the registered count.
- Stall: P, stack pointer, stack contents and error flags all frozen; op and clearErr are ignored.
- Reset mid-sequence (e.g. asserted with CALL): reset wins; the stack is emptied and no push occurs.
- Sticky flags stay set until clearErr (unstalled) or reset.

Decomposition:
- Shared package pc_pkg holds:
  - op encoding constants (PC_NEXT, PC_HOLD, PC_BRANCH, PC_JUMP, PC_CALL, PC_RET);
  - default width constants, reused by decode/control.
- One sub-module, return_address_stack:
  - parametrised by ADDR_WIDTH and RAS_DEPTH;
  - circular buffer with top pointer and count;
  - push/pop inputs, top-of-stack output, full/empty outputs;
  - overwrite-oldest on push-when-full.
- The top level holds the PC register, next-PC mux, adder and sticky flags.

Test Plan (default parameters unless noted):
1. Reset then NEXT ×3 → outputAddress 0000, then 0002, 0004, 0006 on successive edges; rasEmpty = 1.
2. JUMP inputAddress = AAAA, then BRANCH offset = 12'hFFC (−4), then BRANCH offset = 12'h010 → AAAA, AAA6, AAB6. Also: P = FFFE with NEXT → 0000 (wrap).
3. Call/return sequence:
   - at P = 1000: CALL 2000; at P = 2000: CALL 3000; then RET, RET;
   - → P: 2000, 3000, 2002, 1002;
   - rasEmpty toggles 1→0→1; no error flags.
4. Overflow:
   - CALL ×5 with targets 0100, 0200, 0300, 0400, 0500, starting at P = 0000;
   - → rasFull after the 4th CALL; rasOverflow = 1 after the 5th;
   - 4 RETs yield 0502? No: return values are 0402, 0302, 0202, 0102, since the first push (0002) was overwritten;
   - 5th RET → 0104 (fall through) and rasUnderflow = 1.
5. Stall and clear:
   - with stall = 1, assert CALL/JUMP/clearErr for 3 cycles → outputAddress, rasFull/rasEmpty and error flags all unchanged;
   - release stall and assert clearErr → both error flags 0 next edge.
6. reset = 1 asserted together with CALL while the stack holds 2 entries → next edge: outputAddress = RESET_ADDR, rasEmpty = 1, all flags 0.
